// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone B3 encodings for the main-RAM arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone B3 burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module wb_arb_rr_pick #(
    parameter int N  = 3,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [LW-1:0] i_last,
    output logic [N-1:0]  o_grant
);

    // Walk the ring once starting just after the previous owner
    always_comb begin
        logic w_found;
        int   w_idx;
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= N; i++) begin
            w_idx = (int'(i_last) + i) % N;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter in front of the single main-RAM slave.
// Ownership lasts a whole cyc so bursts stay intact; a watchdog ends stalled strobes with err.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int N  = NUM_MASTERS;
    localparam int SW = DW / 8;
    localparam int LW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Per-master views of the flattened request buses
    logic [N-1:0][AW-1:0] w_adr;
    logic [N-1:0][DW-1:0] w_dat;
    logic [N-1:0][SW-1:0] w_sel;
    logic [N-1:0][2:0]    w_cti;
    logic [N-1:0][1:0]    w_bte;

    assign w_adr = m_adr_i;
    assign w_dat = m_dat_i;
    assign w_sel = m_sel_i;
    assign w_cti = m_cti_i;
    assign w_bte = m_bte_i;

    arb_state_t    r_state, w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_pick;
    logic [LW-1:0] r_last;
    logic [LW-1:0] w_own_idx;
    logic [TW-1:0] r_wdog;
    logic          r_abort;   // watchdog fired; slave is cut off until the owner releases
    logic          w_own_cyc, w_own_stb, w_resp, w_timeout, w_live;

    wb_arb_rr_pick #(.N(N), .LW(LW)) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    // Owner status; a slave response in the expiry cycle beats the watchdog
    always_comb begin
        w_own_cyc = |(m_cyc_i & r_grant);
        w_own_stb = |(m_stb_i & r_grant);
        w_own_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (r_grant[k]) w_own_idx = LW'(k);
        end
        w_resp    = s_ack_i | s_err_i | s_rty_i;
        w_timeout = (r_state == BUSY) & w_own_cyc & w_own_stb & ~w_resp & ~r_abort &
                    (r_wdog == TW'(TIMEOUT - 1));
        w_live    = (r_state == BUSY) & w_own_cyc & ~r_abort & ~w_timeout;
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: claim on any request, release when the owner drops cyc
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|m_cyc_i)  w_state_nxt = BUSY;
            BUSY:    if (!w_own_cyc) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant and last-owner pointer; pointer starts at the top so port 0 wins first
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_grant <= '0;
            r_last  <= LW'(N - 1);
        end else if (r_state == IDLE && |m_cyc_i) begin
            r_grant <= w_pick;
        end else if (r_state == BUSY && !w_own_cyc) begin
            r_grant <= '0;
            r_last  <= w_own_idx;
        end
    end

    // Watchdog counts unanswered strobe cycles of the current owner
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state == IDLE || !w_own_cyc) begin
            r_wdog  <= '0;
            r_abort <= 1'b0;
        end else if (w_timeout) begin
            r_wdog  <= '0;
            r_abort <= 1'b1;
        end else if (w_own_stb && !w_resp && !r_abort) begin
            r_wdog  <= r_wdog + TW'(1);
        end else begin
            r_wdog  <= '0;
        end
    end

    // Control outputs: slave cycle gating and single response routed to the owner
    always_comb begin
        s_cyc_o = w_live;
        s_stb_o = w_live & w_own_stb;
        m_ack_o = r_grant & {N{w_live & s_ack_i}};
        m_err_o = r_grant & {N{(w_live & ~s_ack_i & s_err_i) | w_timeout}};
        m_rty_o = r_grant & {N{w_live & ~s_ack_i & ~s_err_i & s_rty_i}};
        grant_o = r_grant;
    end

    // AND-OR request mux over the one-hot grant
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < N; k++) begin
            s_adr_o = s_adr_o | (w_adr[k] & {AW{r_grant[k]}});
            s_dat_o = s_dat_o | (w_dat[k] & {DW{r_grant[k]}});
            s_sel_o = s_sel_o | (w_sel[k] & {SW{r_grant[k]}});
            s_we_o  = s_we_o  | (m_we_i[k] & r_grant[k]);
            s_cti_o = s_cti_o | (w_cti[k] & {3{r_grant[k]}});
            s_bte_o = s_bte_o | (w_bte[k] & {2{r_grant[k]}});
        end
    end

    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: scripted masters, a reactive slave, an owner-level model
// compared every cycle, and literal expectations for each scenario.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic [N*AW-1:0]     m_adr_i;
    logic [N*DW-1:0]     m_dat_i;
    logic [N*DW/8-1:0]   m_sel_i;
    logic [N-1:0]        m_we_i, m_cyc_i, m_stb_i;
    logic [N*3-1:0]      m_cti_i;
    logic [N*2-1:0]      m_bte_i;
    logic [DW-1:0]       m_dat_o;
    logic [N-1:0]        m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]          s_cti_o;
    logic [1:0]          s_bte_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i, s_err_i, s_rty_i;

    wb_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- scripted masters ----------------
    int             pend[N], beats[N], ehold[N], left[N], hcnt[N];
    logic           c_cyc[N], c_stb[N];
    logic [AW-1:0]  c_adr[N];
    logic [DW-1:0]  c_dat[N];
    logic [2:0]     c_cti[N];

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 0; beats[k] = 1; ehold[k] = 0; left[k] = 0; hcnt[k] = 0;
            c_cyc[k] = 0; c_stb[k] = 0; c_adr[k] = '0; c_dat[k] = '0; c_cti[k] = '0;
        end
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
        forever begin
            @(negedge wb_clk_i);
            for (int k = 0; k < N; k++) begin
                if (c_cyc[k]) begin
                    if (hcnt[k] > 0) begin
                        hcnt[k]--;
                        if (hcnt[k] == 0) c_cyc[k] = 0;
                    end else if (m_ack_o[k]) begin
                        left[k]--;
                        c_adr[k] = c_adr[k] + 32'd4;
                        c_dat[k] = $urandom;
                        if (left[k] == 0) begin c_cyc[k] = 0; c_stb[k] = 0; c_cti[k] = '0; end
                        else if (left[k] == 1) c_cti[k] = CTI_EOB;
                    end else if (m_err_o[k] || m_rty_o[k]) begin
                        c_stb[k] = 0;
                        if (ehold[k] > 0) hcnt[k] = ehold[k];
                        else c_cyc[k] = 0;
                    end
                end else if (pend[k] > 0) begin
                    pend[k]--;
                    left[k]  = beats[k];
                    c_cyc[k] = 1; c_stb[k] = 1;
                    c_adr[k] = 32'h1000 * (k + 1);
                    c_dat[k] = $urandom;
                    c_cti[k] = (beats[k] > 1) ? CTI_INCR : CTI_CLASSIC;
                end
            end
            @(posedge wb_clk_i); #1;
            for (int k = 0; k < N; k++) begin
                m_cyc_i[k] = c_cyc[k];
                m_stb_i[k] = c_stb[k];
                m_we_i[k]  = (k == 1);
                m_adr_i[k*AW +: AW]  = c_adr[k];
                m_dat_i[k*DW +: DW]  = c_dat[k];
                m_sel_i[k*4 +: 4]    = 4'hF - 4'(k);
                m_cti_i[k*3 +: 3]    = c_cti[k];
                m_bte_i[k*2 +: 2]    = 2'(k);
            end
        end
    end

    // ---------------- reactive slave ----------------
    // Responds slv_delay cycles after a strobe is first seen; 0 means never.
    int slv_delay = 1;
    int slv_kind  = 0;   // 0 ack, 1 err, 2 rty, 3 all three at once
    bit late_ack  = 0;

    initial begin
        int  spend;
        bit  fire;
        spend = 0;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i)) spend++;
            else spend = 0;
            fire = (slv_delay != 0) && (spend == slv_delay);
            @(posedge wb_clk_i); #1;
            s_ack_i = (fire && (slv_kind == 0 || slv_kind == 3)) || late_ack;
            s_err_i = fire && (slv_kind == 1 || slv_kind == 3);
            s_rty_i = fire && (slv_kind == 2 || slv_kind == 3);
            s_dat_i = $urandom;
        end
    end

    // ---------------- owner-level model ----------------
    typedef struct packed {
        logic         s_cyc;
        logic         s_stb;
        logic         tout;
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic [N-1:0] err;
        logic [N-1:0] rty;
    } exp_t;

    int mo = -1;       // owner index, -1 when nobody holds the slave
    int ml = N - 1;    // previous owner
    int mw = 0;        // unanswered strobe cycles so far
    bit ma = 0;        // owner was cut off by the watchdog

    function automatic exp_t calc();
        exp_t e;
        bit   oc, os, rsp, live;
        e = '0;
        if (mo >= 0) begin
            oc  = m_cyc_i[mo];
            os  = m_stb_i[mo];
            rsp = s_ack_i || s_err_i || s_rty_i;
            e.grant[mo] = 1'b1;
            e.tout  = oc && os && !rsp && !ma && (mw == TO - 1);
            live    = oc && !ma && !e.tout;
            e.s_cyc = live;
            e.s_stb = live && os;
            if (live && s_ack_i)      e.ack[mo] = 1'b1;
            else if (live && s_err_i) e.err[mo] = 1'b1;
            else if (live && s_rty_i) e.rty[mo] = 1'b1;
            if (e.tout) e.err[mo] = 1'b1;
        end
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge wb_clk_i);
            e = calc();
            if (wb_rst_i) begin
                mo = -1; ml = N - 1; mw = 0; ma = 0;
            end else if (mo < 0) begin
                for (int i = 1; i <= N; i++)
                    if (mo < 0 && m_cyc_i[(ml + i) % N]) mo = (ml + i) % N;
            end else if (!m_cyc_i[mo]) begin
                ml = mo; mo = -1; mw = 0; ma = 0;
            end else if (e.tout) begin
                mw = 0; ma = 1;
            end else if (m_stb_i[mo] && !(s_ack_i || s_err_i || s_rty_i) && !ma) begin
                mw++;
            end else begin
                mw = 0;
            end
        end
    end

    // ---------------- per-cycle compare and history ----------------
    bit           cmp_en = 0;
    int           gq[$];
    logic [N-1:0] prev_g = '0;
    int           nack[N], nerr[N], nrty[N];

    initial begin
        exp_t e;
        for (int k = 0; k < N; k++) begin nack[k] = 0; nerr[k] = 0; nrty[k] = 0; end
        forever begin
            @(negedge wb_clk_i);
            if (cmp_en) begin
                e = calc();
                chk("s_cyc", 32'(s_cyc_o), 32'(e.s_cyc));
                chk("s_stb", 32'(s_stb_o), 32'(e.s_stb));
                chk("grant", 32'(grant_o), 32'(e.grant));
                chk("m_ack", 32'(m_ack_o), 32'(e.ack));
                chk("m_err", 32'(m_err_o), 32'(e.err));
                chk("m_rty", 32'(m_rty_o), 32'(e.rty));
                chk("m_dat", m_dat_o, s_dat_i);
                if (mo >= 0) begin
                    chk("s_adr", s_adr_o, m_adr_i[mo*AW +: AW]);
                    chk("s_dat", s_dat_o, m_dat_i[mo*DW +: DW]);
                    chk("s_sel", 32'(s_sel_o), 32'(m_sel_i[mo*4 +: 4]));
                    chk("s_we",  32'(s_we_o),  32'(m_we_i[mo]));
                    chk("s_cti", 32'(s_cti_o), 32'(m_cti_i[mo*3 +: 3]));
                    chk("s_bte", 32'(s_bte_o), 32'(m_bte_i[mo*2 +: 2]));
                end else begin
                    chk("idle_slave", {s_adr_o[15:0], 9'd0, s_we_o, s_cti_o, s_bte_o}, 32'd0);
                end
                if (grant_o != prev_g && grant_o != '0)
                    for (int k = 0; k < N; k++) if (grant_o[k]) gq.push_back(k);
                prev_g = grant_o;
                for (int k = 0; k < N; k++) begin
                    if (m_ack_o[k]) nack[k]++;
                    if (m_err_o[k]) nerr[k]++;
                    if (m_rty_o[k]) nrty[k]++;
                end
            end
        end
    end

    function automatic bit quiet();
        bit q = (grant_o == '0);
        for (int k = 0; k < N; k++) if (pend[k] != 0 || c_cyc[k]) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input string nm);
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge wb_clk_i);
            done = quiet();
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stalled");
    end

    // ---------------- scenarios ----------------
    initial begin
        int a, b, cnt, code, n;
        bit ok, seen;
        wb_rst_i = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = 1;

        // Reset held with all three masters requesting
        @(posedge wb_clk_i); #1;
        cmp_en = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
            chk("rst_grant", 32'(grant_o), 32'd0);
        end
        @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;

        // Contention after reset: grants 0,1,2 in order
        wait_quiet("t2_quiet");
        code = (gq.size() == 3) ? gq[0] * 100 + gq[1] * 10 + gq[2] : -1;
        chk("t2_order", 32'(code), 32'd12);

        // Burst on port 1, port 0 requests mid-burst
        gq.delete();
        a = nack[1]; b = nack[0];
        beats[1] = 4; pend[1] = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge wb_clk_i);
            seen = m_ack_o[1];
        end
        chk("t3_first_ack", 32'(seen), 32'd1);
        pend[0] = 1;
        wait_quiet("t3_quiet");
        beats[1] = 1;
        chk("t3_acks_p1", 32'(nack[1] - a), 32'd4);
        chk("t3_acks_p0", 32'(nack[0] - b), 32'd1);
        code = (gq.size() == 2) ? gq[0] * 10 + gq[1] : -1;
        chk("t3_order", 32'(code), 32'd10);

        // Fairness: ports 0 and 2 keep re-requesting
        gq.delete();
        pend[0] = 12; pend[2] = 12;
        wait_quiet("t5_quiet");
        chk("t5_grants", 32'(gq.size()), 32'd24);
        ok = (gq.size() > 0);
        for (int i = 1; i < gq.size(); i++)
            if (gq[i] == gq[i-1] || (gq[i] != 0 && gq[i] != 2)) ok = 0;
        chk("t5_alternate", 32'(ok), 32'd1);

        // Watchdog: slave silent, err pulses on the TO-th wait cycle
        slv_delay = 0; ehold[1] = 3; pend[1] = 1;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (m_err_o != '0) seen = 1;
            else if (s_cyc_o) cnt++;
        end
        chk("t4_err_vec", 32'(m_err_o), 32'h2);
        chk("t4_wait_cycles", 32'(cnt), 32'(TO - 1));
        chk("t4_cyc_low", 32'(s_cyc_o), 32'd0);
        late_ack = 1;
        @(negedge wb_clk_i);
        late_ack = 0;
        chk("t4_late_ack_ignored", 32'(m_ack_o), 32'd0);
        chk("t4_err_single", 32'(m_err_o), 32'd0);
        wait_quiet("t4_quiet");
        ehold[1] = 0;

        // Slave answers in the very cycle the watchdog would fire
        slv_delay = TO - 1;
        a = nack[1]; b = nerr[1];
        pend[1] = 1;
        wait_quiet("t4b_quiet");
        chk("t4b_ack", 32'(nack[1] - a), 32'd1);
        chk("t4b_no_err", 32'(nerr[1] - b), 32'd0);

        // Slave err, rty, and all three together (ack wins)
        slv_delay = 1;
        for (int kind = 1; kind <= 3; kind++) begin
            slv_kind = kind;
            a = nack[0]; b = nerr[0]; n = nrty[0];
            pend[0] = 1;
            wait_quiet("resp_quiet");
            code = (nack[0] - a) * 100 + (nerr[0] - b) * 10 + (nrty[0] - n);
            chk("resp_kind", 32'(code), (kind == 1) ? 32'd10 : (kind == 2) ? 32'd1 : 32'd100);
        end
        slv_kind = 0;

        // Reset on the second beat of a burst
        beats[1] = 4; pend[1] = 1;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge wb_clk_i);
            if (m_ack_o[1]) n++;
        end
        chk("t6_beat2", 32'(n), 32'd2);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        pend[0] = 1; pend[2] = 1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        chk("t6_cyc_dropped", 32'(s_cyc_o), 32'd0);
        chk("t6_grant_clear", 32'(grant_o), 32'd0);
        gq.delete();
        wait_quiet("t6_quiet");
        beats[1] = 1;
        chk("t6_first_owner", (gq.size() > 0) ? 32'(gq[0]) : 32'hFF, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
